// File: rtl/acc_bus_pkg.sv
// Shared types and constants for the accumulator/addend bus sequencer.
package acc_bus_pkg;

  // Default datapath and run-length widths
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_FIRST,
    ST_LOAD_ADDEND,
    ST_ADD,
    ST_DONE
  } state_e;

  // Strobe vector encodings, ordered {EnIn, EnAd, LdAc, LdAd}
  localparam logic [3:0] CTL_IDLE    = 4'b0000;
  localparam logic [3:0] CTL_LDAC_IN = 4'b1010;
  localparam logic [3:0] CTL_LDAD_IN = 4'b1001;
  localparam logic [3:0] CTL_ADD     = 4'b0110;

endpackage

// File: rtl/acc_bus_sequencer_if.sv
// Operand stream, run control and datapath strobe bundle for the sequencer.
interface acc_bus_sequencer_if
  import acc_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] input_data;
  logic              EnIn;
  logic              EnAd;
  logic              LdAc;
  logic              LdAd;
  logic              busy;
  logic              done;

  // Sequencer side
  modport slave (
    input  start, len, abort, in_valid, in_data,
    output in_ready, input_data, EnIn, EnAd, LdAc, LdAd, busy, done
  );

  // Operand source / controller side
  modport master (
    output start, len, abort, in_valid, in_data,
    input  in_ready, input_data, EnIn, EnAd, LdAc, LdAd, busy, done
  );
endinterface

// File: rtl/acc_seq_counter.sv
// Loadable down-counter tracking the operands still to be accepted in a run.
module acc_seq_counter #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_o,
  output logic             is_zero_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins over decrement; never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one_o  = (count_q == ONE);
  assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/acc_bus_sequencer.sv
// Control sequencer for the accumulator/addend bus datapath: loads the first
// operand into the accumulator, then alternates addend load and add-back.
module acc_bus_sequencer
  import acc_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  acc_bus_sequencer_if.slave   bus
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] ctl;
  logic       ready;
  logic       done_pulse;
  logic       cnt_load;
  logic       cnt_dec;
  logic       rem_is_one;
  logic       rem_is_zero;

  acc_seq_counter #(
    .CNT_W (CNT_W)
  ) u_remaining (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load_i     (cnt_load),
    .load_val_i (bus.len),
    .dec_i      (cnt_dec),
    .is_one_o   (rem_is_one),
    .is_zero_o  (rem_is_zero)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; abort silences everything in its cycle
  always_comb begin
    state_d    = state_q;
    ctl        = CTL_IDLE;
    ready      = 1'b0;
    done_pulse = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.abort && bus.start) begin
          if (bus.len != '0) begin
            cnt_load = 1'b1;
            state_d  = ST_LOAD_FIRST;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_LOAD_FIRST: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          ready = 1'b1;
          if (bus.in_valid) begin
            ctl     = CTL_LDAC_IN;
            cnt_dec = 1'b1;
            state_d = rem_is_one ? ST_DONE : ST_LOAD_ADDEND;
          end
        end
      end
      ST_LOAD_ADDEND: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          ready = 1'b1;
          if (bus.in_valid) begin
            ctl     = CTL_LDAD_IN;
            cnt_dec = 1'b1;
            state_d = ST_ADD;
          end
        end
      end
      ST_ADD: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          ctl     = CTL_ADD;
          state_d = rem_is_zero ? ST_DONE : ST_LOAD_ADDEND;
        end
      end
      ST_DONE: begin
        done_pulse = !bus.abort;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = ready;
  assign bus.input_data = DATA_W'(bus.in_data);
  assign bus.EnIn       = ctl[3];
  assign bus.EnAd       = ctl[2];
  assign bus.LdAc       = ctl[1];
  assign bus.LdAd       = ctl[0];
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_pulse;

endmodule

// File: tb/tb_acc_bus_sequencer.sv
// Directed self-checking bench for acc_bus_sequencer with a behavioural
// accumulator/addend datapath attached to the strobes.
module tb_acc_bus_sequencer;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  acc_bus_sequencer_if #(.DATA_W(8), .CNT_W(4)) bus ();

  acc_bus_sequencer #(.DATA_W(8), .CNT_W(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural datapath: bus mux feeding accumulator and addend registers
  logic [7:0] acc_q;
  logic [7:0] add_q;
  logic [7:0] dp_bus;
  logic [3:0] ctl;

  assign ctl    = {bus.EnIn, bus.EnAd, bus.LdAc, bus.LdAd};
  assign dp_bus = bus.EnIn ? bus.input_data : (bus.EnAd ? 8'(acc_q + add_q) : 8'd0);

  // Datapath captures on the edge that completes the handshake
  always @(posedge CLK) begin
    if (bus.LdAc) acc_q <= dp_bus;
    if (bus.LdAd) add_q <= dp_bus;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] ops [0:15];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ctl"},   32'(ctl),          32'd0);
    check_val({tag, "_rdy"},   32'(bus.in_ready), 32'd0);
    check_val({tag, "_busy"},  32'(bus.busy),     32'd0);
    check_val({tag, "_done"},  32'(bus.done),     32'd0);
  endtask

  // No-stall run of n operands from ops[]; optional start/len=5 noise while busy
  task automatic run_ops(input int n, input logic [7:0] exp_sum, input bit noisy);
    logic [3:0] idx;
    logic [3:0] exp_ctl;
    logic       exp_rdy;
    bus.start    = 1'b1;
    bus.len      = 4'(n);
    bus.in_valid = 1'b1;
    bus.in_data  = ops[0];
    #1;
    check_val("pre_start_busy", 32'(bus.busy), 32'd0);
    tick();
    idx = 4'd0;
    for (int c = 1; c <= 2 * n; c++) begin
      bus.start    = noisy && (c < 2 * n);
      bus.len      = noisy ? 4'd5 : 4'(n);
      bus.in_valid = 1'b1;
      bus.in_data  = ops[idx];
      #1;
      if (c == 1)              exp_ctl = 4'b1010;
      else if (c == 2 * n)     exp_ctl = 4'b0000;
      else if (c % 2 == 0)     exp_ctl = 4'b1001;
      else                     exp_ctl = 4'b0110;
      exp_rdy = (c == 1) || ((c < 2 * n) && (c % 2 == 0));
      check_val($sformatf("n%0d_ctl_c%0d", n, c),  32'(ctl),          32'(exp_ctl));
      check_val($sformatf("n%0d_rdy_c%0d", n, c),  32'(bus.in_ready), 32'(exp_rdy));
      check_val($sformatf("n%0d_done_c%0d", n, c), 32'(bus.done),     32'(c == 2 * n));
      check_val($sformatf("n%0d_busy_c%0d", n, c), 32'(bus.busy),     32'd1);
      if (exp_rdy) idx = idx + 4'd1;
      tick();
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_quiet($sformatf("n%0d_after", n));
    check_val($sformatf("n%0d_acc", n), 32'(acc_q), 32'(exp_sum));
    tick();
    check_val($sformatf("n%0d_done_once", n), 32'(bus.done), 32'd0);
    $display("run len=%0d noisy=%0d acc=%0d", n, noisy, acc_q);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.len      = 4'd0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    // Reset state
    tick();
    check_quiet("reset");
    tick();
    RST_N = 1'b1;
    #1;
    check_quiet("post_reset");
    $display("reset released");

    // len=3: 15+13+93 = 121
    ops[0] = 8'd15; ops[1] = 8'd13; ops[2] = 8'd93; ops[3] = 8'd0;
    run_ops(3, 8'd121, 1'b0);

    // len=2 with wrap: 200+100 = 300 mod 256 = 44; start/len=5 while busy ignored
    ops[0] = 8'd200; ops[1] = 8'd100; ops[2] = 8'd0;
    run_ops(2, 8'd44, 1'b1);

    // Stall in LOAD_ADDEND: 10+20 = 30
    bus.start = 1'b1; bus.len = 4'd2; bus.in_valid = 1'b1; bus.in_data = 8'd10;
    tick();
    bus.start = 1'b0;
    #1;
    check_val("stall_first_ctl", 32'(ctl), 32'b1010);
    tick();
    bus.in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_val($sformatf("stall_ctl_s%0d", s), 32'(ctl),          32'd0);
      check_val($sformatf("stall_rdy_s%0d", s), 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = 1'b1; bus.in_data = 8'd20;
    #1;
    check_val("stall_accept_ctl", 32'(ctl), 32'b1001);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check_val("stall_add_ctl", 32'(ctl), 32'b0110);
    check_val("stall_add_done", 32'(bus.done), 32'd0);
    tick();
    check_val("stall_done", 32'(bus.done), 32'd1);
    check_val("stall_done_ctl", 32'(ctl), 32'd0);
    tick();
    check_val("stall_acc", 32'(acc_q), 32'd30);
    check_quiet("stall_after");
    $display("stall run acc=%0d", acc_q);

    // len=0: done on the next cycle with no strobes
    bus.start = 1'b1; bus.len = 4'd0;
    tick();
    bus.start = 1'b0;
    #1;
    check_val("len0_done", 32'(bus.done), 32'd1);
    check_val("len0_busy", 32'(bus.busy), 32'd1);
    check_val("len0_ctl",  32'(ctl),      32'd0);
    tick();
    check_quiet("len0_after");
    $display("empty run done");

    // start together with abort in IDLE: stays idle
    bus.start = 1'b1; bus.len = 4'd2; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    #1;
    check_quiet("idle_abort");
    $display("start+abort in idle");

    // Reset mid-run in LOAD_ADDEND: outputs drop immediately
    bus.start = 1'b1; bus.len = 4'd3; bus.in_valid = 1'b1; bus.in_data = 8'd7;
    tick();
    bus.start = 1'b0;
    #1;
    check_val("mid_first_ctl", 32'(ctl), 32'b1010);
    tick();
    check_val("mid_addend_ctl", 32'(ctl), 32'b1001);
    RST_N = 1'b0;
    #1;
    check_quiet("mid_reset");
    bus.in_valid = 1'b0;
    tick();
    RST_N = 1'b1;
    #1;
    check_quiet("mid_release");
    $display("reset mid-run");

    // len=1 after reset: single 1010, acc=47
    ops[0] = 8'd47; ops[1] = 8'd0;
    run_ops(1, 8'd47, 1'b0);

    // Abort in ADD with remaining=1
    bus.start = 1'b1; bus.len = 4'd3; bus.in_valid = 1'b1; bus.in_data = 8'd1;
    tick();
    bus.start = 1'b0;
    #1;
    check_val("abort_first_ctl", 32'(ctl), 32'b1010);
    tick();
    bus.in_data = 8'd2;
    #1;
    check_val("abort_addend_ctl", 32'(ctl), 32'b1001);
    tick();
    bus.abort = 1'b1;
    #1;
    check_val("abort_cycle_ctl", 32'(ctl),          32'd0);
    check_val("abort_cycle_rdy", 32'(bus.in_ready), 32'd0);
    check_val("abort_cycle_done", 32'(bus.done),    32'd0);
    tick();
    bus.abort = 1'b0;
    #1;
    check_quiet("abort_next");
    tick();
    check_quiet("abort_next2");
    bus.in_valid = 1'b0;
    $display("abort in add");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acc_bus_sequencer.md
Name: acc_bus_sequencer

Overview:
- Control sequencer sitting directly upstream of the accumulator/addend bus datapath.
- Accepts a run of N operands over a valid/ready stream and drives input_data plus the four datapath strobes EnIn, EnAd, LdAc and LdAd.
- Loads the first operand into the accumulator, then alternates load-addend and add-back for each further operand.
- Pulses done when the accumulator holds the sum mod 2^DATA_W.

Parameters:
- DATA_W, 8, operand/bus width; must match the datapath.
- CNT_W, 4, width of the operand-count field len; max run length 2^CNT_W-1.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- len  in  CNT_W  operand count for the run, sampled with start.
- abort  in  1  synchronous abort; returns to IDLE, no done.
- in_valid  in  1  operand available.
- in_data  in  DATA_W  operand value.
- in_ready  out  1  sequencer can take an operand this cycle.
- input_data  out  DATA_W  to datapath; combinational copy of in_data.
- EnIn  out  1  datapath bus select: input_data.
- EnAd  out  1  datapath bus select: accumulator+addend.
- LdAc  out  1  datapath accumulator load.
- LdAd  out  1  datapath addend load.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (RST_N low, async): state=IDLE, remaining=0. in_ready, EnIn, EnAd, LdAc, LdAd, busy and done all 0.
- Reset does not touch datapath registers; their contents are undefined to this block after reset.
- States: IDLE, LOAD_FIRST, LOAD_ADDEND, ADD, DONE.
- IDLE:
  - start with len>0: load remaining=len, go to LOAD_FIRST.
  - start with len=0: go to DONE (empty run; done pulses, no datapath strobes).
  - Otherwise stay.
- LOAD_FIRST:
  - in_ready=1.
  - Accept = in_valid & in_ready. On accept: EnIn=1, LdAc=1 (same cycle, combinational); remaining decrements at the edge.
  - Next state: DONE if remaining was 1, else LOAD_ADDEND.
  - No accept: stay, all strobes 0.
- LOAD_ADDEND:
  - in_ready=1.
  - On accept: EnIn=1, LdAd=1; remaining decrements; next state ADD.
  - No accept: stay.
- ADD:
  - Unconditional single cycle: EnAd=1, LdAc=1, in_ready=0.
  - Next state: DONE if remaining==0, else LOAD_ADDEND.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE.
- Strobe invariants:
  - EnIn and EnAd are never both 1.
  - LdAc and LdAd are never both 1.
  - All strobes are 0 in IDLE and DONE.
  - The datapath captures on the same posedge that completes the handshake.
- Latency with no stalls: N operands take 1 + 2(N-1) busy cycles before DONE. done is high in cycle 2N after the start edge.
- Arithmetic: the sum wraps mod 2^DATA_W inside the datapath; the sequencer does no arithmetic on data.
- start while busy: ignored, no effect on len or remaining.
- abort:
  - Has priority over all transitions in every state except IDLE.
  - Next state IDLE; strobes forced 0 in the abort cycle; in_ready=0 in the abort cycle; no done.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- in_valid held while in_ready=0 (ADD, DONE, IDLE): operand is not consumed and must stay presented.

Decomposition:
- Shared package acc_bus_pkg:
  - state enum (IDLE, LOAD_FIRST, LOAD_ADDEND, ADD, DONE).
  - localparams for the strobe vector {EnIn,EnAd,LdAc,LdAd}: CTL_IDLE=0000, CTL_LDAC_IN=1010, CTL_LDAD_IN=1001, CTL_ADD=0110.
  - DATA_W default.
- One sub-module, acc_seq_counter:
  - Loadable CNT_W down-counter with load, dec and is_one/is_zero flags.
  - Asynchronous active-low reset on RST_N.
- FSM and strobe decode stay in the top module.

Test Plan:
- Reset mid-run: drop RST_N during LOAD_ADDEND -> all outputs 0 immediately (async). After release, IDLE, busy=0, a new start is accepted.
- len=3, operands 15,13,93, in_valid always high:
  - Strobe sequence 1010,1001,0110,1001,0110.
  - done in cycle 6 after the start edge.
  - Bench datapath accumulator reads 121.
- len=2, operands 200,100 -> accumulator reads 44 (wraps mod 256); done pulses once.
- Stall: len=2, in_valid low for 3 cycles in LOAD_ADDEND -> strobes stay 0000 and in_ready stays 1 throughout. The operand is accepted on the cycle in_valid rises, and done follows 2 cycles later.
- len=0 start -> done on the next cycle, no strobes. len=1 with operand 47 -> single 1010, accumulator=47, done on the following cycle.
- abort in ADD with remaining=1 -> IDLE next, no done, no further strobes. start with len=5 during busy is ignored.
